// File: rtl/caq_tape_player.sv
// Cassette playback stage: byte FIFO feeding an Aquarius tape-waveform serialiser.
// Build option: define CAQ_LEADER_EN to emit a '1'-tone leader before each playback start.
module caq_tape_player #(
  parameter int FIFO_AW     = 4,
  parameter int HALF_CLKS   = 833,
  parameter int LEADER_BITS = 64
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       WR,
  input  logic [7:0] WR_DATA,
  input  logic       PLAY,
  input  logic       STOP,
  output logic       CASS_IN,
  output logic       BUSY,
  output logic       EMPTY,
  output logic       FULL,
  output logic       OVERFLOW
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int HW    = $clog2(2 * HALF_CLKS);
  localparam logic [HW-1:0] H_LAST = HW'(HALF_CLKS - 1);
  localparam logic [HW-1:0] D_LAST = HW'(2 * HALF_CLKS - 1);

`ifdef CAQ_LEADER_EN
  typedef enum logic [2:0] {S_IDLE, S_LEADER, S_LOAD, S_START, S_DATA, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t state, state_nxt;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [FIFO_AW:0]   count;
  logic               ovf;
  logic               push, pop;

  logic [HW-1:0] hc;
  logic [1:0]    ph;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          cass_q;
  logic          cur_bit, ph_end, bit_end, tone;

  assign EMPTY    = (count == '0);
  assign FULL     = (count == (FIFO_AW+1)'(DEPTH));
  assign OVERFLOW = ovf;
  assign BUSY     = (state != S_IDLE);
  assign CASS_IN  = cass_q;

  // STOP outranks WR: a write in the STOP cycle vanishes without flagging overflow
  assign push = WR && !FULL && !STOP && !RST;
  assign pop  = (state == S_LOAD);

  always_ff @(posedge CLK) begin
    if (RST || STOP) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (WR && FULL) ovf <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= WR_DATA;
  end

  // '1' bits use four H phases, '0' bits two 2H phases; both start high on phase 0
  always_comb begin
    cur_bit = 1'b1;
    case (state)
      S_START: cur_bit = 1'b0;
      S_DATA:  cur_bit = shreg[0];
      default: cur_bit = 1'b1;
    endcase
  end

  assign ph_end  = (hc == (cur_bit ? H_LAST : D_LAST));
  assign bit_end = ph_end && (ph == (cur_bit ? 2'd3 : 2'd1));

`ifdef CAQ_LEADER_EN
  localparam int LW = $clog2(LEADER_BITS + 1);
  logic [LW-1:0] lcnt;

  assign tone = (state == S_LEADER) || (state == S_START) || (state == S_DATA) || (state == S_STOP);

  always_ff @(posedge CLK) begin
    if (RST || STOP || state != S_LEADER) lcnt <= '0;
    else if (bit_end)                     lcnt <= lcnt + 1'b1;
  end
`else
  assign tone = (state == S_START) || (state == S_DATA) || (state == S_STOP);
`endif

  always_ff @(posedge CLK) begin
    if (RST || STOP) state <= S_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
`ifdef CAQ_LEADER_EN
      S_IDLE:   if (PLAY && !EMPTY) state_nxt = S_LEADER;
      S_LEADER: if (bit_end && lcnt == LW'(LEADER_BITS - 1)) state_nxt = S_LOAD;
`else
      S_IDLE:   if (PLAY && !EMPTY) state_nxt = S_LOAD;
`endif
      S_LOAD:   state_nxt = S_START;
      S_START:  if (bit_end) state_nxt = S_DATA;
      S_DATA:   if (bit_end && idx == 3'd7) state_nxt = S_STOP;
      S_STOP:   if (bit_end && idx == 3'd1) state_nxt = (PLAY && !EMPTY) ? S_LOAD : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST || STOP) begin
      hc     <= '0;
      ph     <= '0;
      idx    <= '0;
      shreg  <= '0;
      cass_q <= 1'b0;
    end else begin
      cass_q <= tone && !ph[0];
      if (tone) begin
        if (ph_end) begin
          hc <= '0;
          ph <= bit_end ? 2'd0 : ph + 2'd1;
        end else begin
          hc <= hc + HW'(1);
        end
      end else begin
        hc <= '0;
        ph <= '0;
      end
      if (state == S_LOAD) begin
        shreg <= mem[rptr];
        idx   <= '0;
      end else if (bit_end && (state == S_DATA || state == S_STOP)) begin
        idx <= idx + 3'd1;
        if (state == S_DATA) shreg <= {1'b0, shreg[7:1]};
      end
    end
  end
endmodule

// File: tb/tb_caq_tape_player.sv
// Randomised bench for caq_tape_player; expected waveforms come from the bit-encoding rules.
module tb_caq_tape_player;
  localparam int AW = 2;
  localparam int H  = 4;
  localparam int LB = 2;
  localparam int BW = 4 * H;
  localparam int FW = 11 * BW;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       WR = 1'b0;
  logic [7:0] WR_DATA = '0;
  logic       PLAY = 1'b0;
  logic       STOP = 1'b0;
  logic       CASS_IN, BUSY, EMPTY, FULL, OVERFLOW;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] model_q[$];
  logic       model_ovf = 1'b0;

  caq_tape_player #(.FIFO_AW(AW), .HALF_CLKS(H), .LEADER_BITS(LB)) dut (
    .CLK(CLK), .RST(RST), .WR(WR), .WR_DATA(WR_DATA), .PLAY(PLAY), .STOP(STOP),
    .CASS_IN(CASS_IN), .BUSY(BUSY), .EMPTY(EMPTY), .FULL(FULL), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // One sample per clock: '1' = H high/H low twice, '0' = 2H high then 2H low
  function automatic logic [FW-1:0] frame_wave(input logic [7:0] d);
    logic [10:0]   bits;
    logic [FW-1:0] w;
    bits = {2'b11, d, 1'b0};
    w = '0;
    for (int k = 0; k < 11; k++)
      for (int j = 0; j < BW; j++)
        w[k*BW + j] = bits[k] ? (((j / H) % 2) == 0) : (j < 2 * H);
    return w;
  endfunction

  function automatic logic [FW-1:0] leader_wave();
    logic [FW-1:0] w;
    w = '0;
    for (int k = 0; k < LB * BW; k++) w[k] = (((k % BW) / H) % 2) == 0;
    return w;
  endfunction

  task automatic wr_byte(input logic [7:0] d);
    WR = 1'b1;
    WR_DATA = d;
    tick();
    WR = 1'b0;
    if (model_q.size() < (1 << AW)) model_q.push_back(d);
    else model_ovf = 1'b1;
  endtask

  task automatic capture(input int n, input int drop_at, output logic [FW-1:0] w);
    w = '0;
    for (int t = 0; t < n; t++) begin
      tick();
      w[t] = CASS_IN;
      if (t == drop_at) PLAY = 1'b0;
    end
  endtask

  // Plays n bytes from the model queue; drop_at >= 0 releases PLAY inside the first byte
  task automatic play_bytes(input int n, input int drop_at);
    logic [FW-1:0] w;
    logic [7:0]    b;
    PLAY = 1'b1;
    tick();
    chk("pre_low", CASS_IN, 0);
    chk("busy_on", BUSY, 1);
`ifdef CAQ_LEADER_EN
    capture(LB * BW, -1, w);
    chk("leader", w, leader_wave());
`endif
    for (int i = 0; i < n; i++) begin
      tick();
      chk("load_gap", CASS_IN, 0);
      b = model_q.pop_front();
      capture(FW, (i == 0) ? drop_at : -1, w);
      chk("byte_wave", w, frame_wave(b));
    end
    PLAY = 1'b0;
    chk("busy_off", BUSY, 0);
    chk("empty_end", EMPTY, (model_q.size() == 0) ? 1 : 0);
    chk("ovf_sticky", OVERFLOW, model_ovf);
  endtask

  initial begin
    logic [FW-1:0] w;
    int n;
    int guard;

    // reset with a coincident write: nothing must be stored
    WR = 1'b1;
    WR_DATA = 8'h77;
    tick();
    RST = 1'b0;
    WR = 1'b0;
    chk("rst_cass", CASS_IN, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_empty", EMPTY, 1);
    chk("rst_full", FULL, 0);
    chk("rst_ovf", OVERFLOW, 0);
    tick();
    chk("rst_nostore", EMPTY, 1);

    // single byte 0x01
    wr_byte(8'h01);
    chk("wr_visible", EMPTY, 0);
    play_bytes(1, -1);

    // overflow: five writes into a four-deep FIFO
    for (int i = 0; i < 5; i++) begin
      wr_byte(8'($urandom_range(0, 255)));
      if (i == 3) chk("full_4th", FULL, 1);
      if (i == 3) chk("ovf_4th", OVERFLOW, 0);
    end
    chk("ovf_5th", OVERFLOW, model_ovf);
    chk("full_5th", FULL, 1);
    play_bytes(4, -1);
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    model_ovf = 1'b0;
    chk("ovf_clr", OVERFLOW, 0);

    // PLAY released during 0xA5's data bits; 0x5A stays queued
    wr_byte(8'hA5);
    wr_byte(8'h5A);
    play_bytes(1, 60);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drop_idle", {BUSY, CASS_IN}, 0);
    end
    play_bytes(1, -1);

    // randomised runs
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) wr_byte(8'($urandom_range(0, 255)));
      chk("rnd_full", FULL, (model_q.size() == (1 << AW)) ? 1 : 0);
      play_bytes(n, -1);
    end

    // STOP during a high phase, with an overflowed FIFO and a coincident write
    for (int i = 0; i < 5; i++) wr_byte(8'($urandom_range(0, 255)));
    PLAY = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    guard = 0;
    while (CASS_IN !== 1'b1 && guard < 16) begin
      tick();
      guard++;
    end
    chk("stop_hi", CASS_IN, 1);
    STOP = 1'b1;
    WR = 1'b1;
    WR_DATA = 8'h3C;
    tick();
    STOP = 1'b0;
    WR = 1'b0;
    PLAY = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    chk("stop_cass", CASS_IN, 0);
    chk("stop_busy", BUSY, 0);
    chk("stop_empty", EMPTY, 1);
    chk("stop_ovf", OVERFLOW, 0);
    tick();
    chk("stop_wr_drop", EMPTY, 1);

    // playback still works after STOP
    wr_byte(8'($urandom_range(0, 255)));
    play_bytes(1, -1);
    capture(4, -1, w);
    chk("tail_low", w, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/caq_tape_player.md
# caq_tape_player

Cassette playback stage for the Aquarius core. It buffers bytes streamed in from the ROM/tape download path in a small FIFO. It serialises each byte into the Aquarius tape waveform and drives the cassette-input pin consumed by the PLA and the audio codec driver. It runs in the CPU clock domain (4 MHz) and replaces a physical tape deck.

## Interface
Parameters:
- `FIFO_AW`, default 4: FIFO address width; depth = 2^FIFO_AW bytes.
- `HALF_CLKS`, default 833: clocks per half-cycle of the 2400 Hz tone (4 MHz / 4800).
- `LEADER_BITS`, default 64: number of '1' bits in the leader tone (used only with the leader feature).

Ports:
- `CLK`, in, 1: CPU clock. One clock; all logic on its rising edge.
- `RST`, in, 1: reset. Synchronous and active-high.
- `WR`, in, 1: write strobe, one byte per cycle when high.
- `WR_DATA`, in, 8: byte to enqueue.
- `PLAY`, in, 1: level; play enable (tape motor).
- `STOP`, in, 1: pulse; abort playback and flush the FIFO.
- `CASS_IN`, out, 1: tape waveform to the PLA.
- `BUSY`, out, 1: state is not IDLE.
- `EMPTY`, out, 1: FIFO empty.
- `FULL`, out, 1: FIFO full.
- `OVERFLOW`, out, 1: sticky flag; a write was dropped.

## Operation
- **FIFO**
  - Registered count of width FIFO_AW+1; read and write pointers of width FIFO_AW, wrapping modulo depth.
  - A write with FULL=1 is dropped and sets OVERFLOW. This includes the case of a write coinciding with a pop while full.
  - A pop happens only in state LOAD.
  - OVERFLOW clears only on RST or STOP.
- **Bit encoding.** Every bit lasts 4·HALF_CLKS clocks and starts with CASS_IN high.
  - '1': high H, low H, high H, low H, where H = HALF_CLKS.
  - '0': high 2H, low 2H.
- **Framing:** start bit '0', 8 data bits LSB first, then 2 stop bits '1'. That is 11 bits per byte.
- **States:** IDLE, LEADER, LOAD, START, DATA, STOP.
  - IDLE: CASS_IN=0. Moves to LEADER (feature on) or LOAD (feature off) when PLAY=1 and EMPTY=0.
  - LEADER: emits LEADER_BITS '1' bits, then moves to LOAD.
  - LOAD: one cycle. Pops the head byte into the shift register and moves to START.
  - START: one '0' bit, then DATA.
  - DATA: 8 bits; a 3-bit index counts 0..7, then STOP.
  - STOP: 2 '1' bits. Then LOAD if PLAY=1 and EMPTY=0, else IDLE.
- **PLAY deasserted mid-byte:** the current byte finishes through its stop bits, then the block returns to IDLE. The FIFO is retained and resumption goes through LEADER again.
- **Underrun** (FIFO empty at the end of STOP): go to IDLE with CASS_IN=0. A later write plus PLAY restarts playback, with a leader if the feature is on.
- **STOP** (any state): the next state is IDLE, CASS_IN=0, FIFO flushed, OVERFLOW cleared. STOP has priority over WR in the same cycle; that write is dropped without setting OVERFLOW.
- **RST:** same effect as STOP. All counters are cleared.

## Timing
- **Reset values:** CASS_IN=0, BUSY=0, EMPTY=1, FULL=0, OVERFLOW=0.
- **FIFO flags:** a write is visible on EMPTY/FULL the following cycle.
- **Playback start latency (feature off):**
  - PLAY sampled high in IDLE at cycle n → LOAD at n+1 → START at n+2.
  - CASS_IN rises at n+2, i.e. registered, visible from cycle n+3.
- **Byte duration:** 11·4·HALF_CLKS, which is 36652 clocks at the defaults.
- **Back-to-back bytes:** the LOAD cycle inserts exactly one extra low-level clock between bytes. Total per byte is 36653 clocks when the FIFO stays non-empty.
- **Half-cycle counter:** counts 0..HALF_CLKS-1 (or 2·HALF_CLKS-1 for '0' phases) and is reset on each phase change. Width is clog2(2·HALF_CLKS).
- **BUSY** reflects the registered state, so it is 1 from the cycle after the IDLE exit.

## Configuration
- **`CAQ_LEADER_EN` defined:** the LEADER state is compiled in. A leader tone of LEADER_BITS '1' bits (256·HALF_CLKS clocks at default) precedes the first byte of every playback start, including after underrun or a PLAY drop.
- **`CAQ_LEADER_EN` undefined:** the LEADER state and its counter are absent. IDLE goes straight to LOAD, and LEADER_BITS is ignored.

## Test plan
- **Reset:** assert RST 1 cycle with WR=1 → CASS_IN=0, EMPTY=1, FULL=0, OVERFLOW=0 and no byte stored.
- **Single byte:** write 0x01, PLAY=1, leader off, HALF_CLKS=4 → waveform 0-bit(8H,8L), '1'(4H4L4H4L), seven '0' bits, two '1' bits. Then IDLE, BUSY=0, EMPTY=1. Total 176 clocks.
- **Overflow:** FIFO_AW=2; write 5 bytes with PLAY=0 → FULL=1 after the 4th, OVERFLOW=1 after the 5th. Playing back yields bytes 1–4 only.
- **PLAY drop:** enqueue 0xA5, 0x5A; drop PLAY during 0xA5's DATA phase → 0xA5 completes, IDLE follows, EMPTY=0. Re-assert PLAY → 0x5A plays.
- **STOP mid-bit:** pulse STOP during a high phase → CASS_IN=0 and BUSY=0 the next cycle, EMPTY=1, OVERFLOW cleared.
- **Leader:** with CAQ_LEADER_EN, LEADER_BITS=2, HALF_CLKS=4 → 32 clocks of '1' tone precede the start bit. Without the macro, the start bit begins 2 cycles after PLAY.
